systolic_ctrl: RTL
==================

# systolic_ctrl

Sequencing controller for the weight-stationary `systolic` array. It accepts one job at a time: it shifts ARRAY_SIZE weight rows into the array, then streams activation vectors into the array's left edge with per-row skew. It de-skews the bottom `output_row` into whole result vectors and reports job completion. It sits between the host-side streams and the `systolic` instance and owns that instance's `load`, `weights` and `activations` inputs.

## Interface
- ARRAY_SIZE, 4, array rows and columns.
- DATA_WIDTH, 4, signed activation and weight element width.
- SUM_WIDTH (derived, not overridable) = DATA_WIDTH*DATA_WIDTH, signed result element width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  job request; sampled only in IDLE.
- num_vecs  in  8  activation vectors in the job; captured on start.
- busy  out  1  high from the cycle after start is accepted until the done cycle inclusive.
- done  out  1  one-cycle pulse at job end.
- w_valid / w_ready  in / out  1 / 1  weight-row handshake.
- w_data  in  ARRAY_SIZE*DATA_WIDTH  weight row; element c at [c*DATA_WIDTH +: DATA_WIDTH].
- a_valid / a_ready  in / out  1 / 1  activation-vector handshake.
- a_data  in  ARRAY_SIZE*DATA_WIDTH  activation vector; element r feeds array row r.
- arr_load  out  1  drives array `load`.
- arr_weights  out  ARRAY_SIZE*DATA_WIDTH  drives array `weights`.
- arr_activations  out  ARRAY_SIZE*DATA_WIDTH  drives array `activations`.
- arr_output_row  in  ARRAY_SIZE*SUM_WIDTH  from array `output_row`.
- r_valid  out  1  result vector valid; no backpressure.
- r_data  out  ARRAY_SIZE*SUM_WIDTH  result; column c at [c*SUM_WIDTH +: SUM_WIDTH].

## Operation
- Reset values: all outputs 0; state IDLE; skew, de-skew and tag registers 0.
- Each array PE registers its weight, activation and sum outputs with one cycle per hop. Weights shift down one row only on cycles with `load`=1 and hold otherwise. The same `reset` drives the array.
- IDLE: on start=1, capture num_vecs and go to LOAD.
- LOAD:
  - w_ready=1.
  - arr_load = w_valid and arr_weights = w_data, combinationally, so a shift occurs only on accepted beats.
  - Rows are supplied bottom-first: beat 0 is row ARRAY_SIZE-1 and beat ARRAY_SIZE-1 is row 0.
  - arr_activations = 0 throughout.
  - After ARRAY_SIZE accepted beats go to STREAM, or to DRAIN if num_vecs=0.
- STREAM:
  - a_ready=1 until num_vecs beats have been accepted.
  - An accepted beat enters the skew line. A cycle with no accepted beat injects a zero bubble.
  - Row r is delayed r cycles beyond row 0.
  - A valid tag enters a tag delay line in parallel with each beat.
  - After the last accepted beat go to DRAIN.
- DRAIN: a_ready=0; bubbles continue to be injected. When the tag line is empty, assert done and busy for one cycle, then go to IDLE.
- De-skew: arr_output_row column c passes through ARRAY_SIZE-c registers, so all columns of one vector appear together on r_data. r_valid = tag line output.
- Arithmetic is performed inside the array: r_data[c] = Σ_r a[r]·w[r][c], signed, wrapping at SUM_WIDTH. The controller does not modify data.
- start while busy is ignored. num_vecs is not re-sampled mid-job.
- Reset mid-job: asynchronous return to IDLE with all registers cleared. There are no partial r_valid or done pulses afterwards.

## Timing
- start sampled at edge of cycle 0; LOAD is active from cycle 1.
- Activation beat accepted in cycle t: row r element is on arr_activations in cycle t+1+r. Column c of the result is on arr_output_row in cycle t+1+ARRAY_SIZE+c.
- r_valid/r_data for that beat appear in cycle t+2*ARRAY_SIZE+1, held for one cycle.
- done is asserted one cycle after the last r_valid. For num_vecs=0, done is asserted in the cycle after the final LOAD beat.
- Best-case job at ARRAY_SIZE=4, num_vecs=4 with valids held high:
  - LOAD in cycles 1–4; a beats in cycles 5–8.
  - r_valid in cycles 14–17.
  - done in cycle 18; busy=0 from cycle 19.
- Input gaps (w_valid=0 or a_valid=0) stretch the schedule cycle-for-cycle. Result order equals input order.

## Test plan
- Identity weights (beats row3..row0 = unit rows), a=[1,2,3,4] → r_valid at cycle 14 with r_data=[1,2,3,4]; done at cycle 15.
- All weights 4'hF (−1), a=[7,7,7,7] → every column 16'hFFE4 (−28).
- Four vectors with a_valid=0 for one cycle between vectors 2 and 3 → four r_valid pulses with a one-cycle gap between the 2nd and 3rd; values match the golden model.
- w_valid toggling 1,0,1,0,… during LOAD → arr_load high only on accepted beats; identity results still correct.
- num_vecs=0 → no r_valid; done exactly one cycle after the 4th weight beat. A start pulse while busy produces no second job.
- reset asserted mid-STREAM → all outputs 0 immediately. After release, a new job with identity weights returns correct results with no stale r_valid.

Source files
------------

// File: rtl/systolic_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_ctrl
//
// Job sequencer for the weight-stationary systolic array. A job loads
// ARRAY_SIZE weight rows into the array (bottom row first). It then streams
// num_vecs activation vectors into the array's left edge. Each row is skewed
// one cycle more than the row above it. Finally the controller realigns the
// skewed bottom output row into whole result vectors.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   start, num_vecs   job request and vector count (captured in IDLE)
//   busy, done        job in progress / one-cycle end-of-job pulse
//   w_valid/w_ready/w_data   weight-row stream (host side)
//   a_valid/a_ready/a_data   activation-vector stream (host side)
//   arr_load, arr_weights, arr_activations   drive the array instance
//   arr_output_row    bottom-row partial sums coming back from the array
//   r_valid, r_data   realigned result vectors, no backpressure
// ---------------------------------------------------------------------------
module systolic_ctrl #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic [7:0]                                   num_vecs,
  output logic                                         busy,
  output logic                                         done,
  input  logic                                         w_valid,
  output logic                                         w_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]             w_data,
  input  logic                                         a_valid,
  output logic                                         a_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]             a_data,
  output logic                                         arr_load,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]             arr_weights,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]             arr_activations,
  input  logic [ARRAY_SIZE*DATA_WIDTH*DATA_WIDTH-1:0]  arr_output_row,
  output logic                                         r_valid,
  output logic [ARRAY_SIZE*DATA_WIDTH*DATA_WIDTH-1:0]  r_data
);

  localparam int SUM_WIDTH = DATA_WIDTH * DATA_WIDTH;
  localparam int TAG_DEPTH = 2 * ARRAY_SIZE + 1;
  localparam int LCW       = $clog2(ARRAY_SIZE + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [LCW-1:0]       w_count;
  logic [7:0]           vecs_left;
  logic [TAG_DEPTH-1:0] tag_line;

  logic w_accept;
  logic a_accept;
  logic last_w_beat;
  logic last_a_beat;
  logic tag_empty;

  // Handshake qualifiers. A weight beat is accepted only in LOAD and an
  // activation beat only in STREAM. Every other cycle is treated as a
  // bubble.
  assign w_accept    = (state == S_LOAD) && w_valid;
  assign a_accept    = (state == S_STREAM) && a_valid;
  assign last_w_beat = w_accept && (w_count == LCW'(ARRAY_SIZE - 1));
  assign last_a_beat = a_accept && (vecs_left == 8'd1);
  assign tag_empty   = (tag_line == '0);

  // Next-state logic for the job sequencer. STREAM is skipped entirely for
  // an empty job. DRAIN waits until the last valid tag has left the tag
  // line, which is the same cycle its result has left r_valid.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start)       state_next = S_LOAD;
      S_LOAD:   if (last_w_beat) state_next = (vecs_left == 8'd0) ? S_DRAIN : S_STREAM;
      S_STREAM: if (last_a_beat) state_next = S_DRAIN;
      S_DRAIN:  if (tag_empty)   state_next = S_IDLE;
      default:                   state_next = S_IDLE;
    endcase
  end

  // State register plus the two job counters. num_vecs is captured only when
  // a job is accepted from IDLE, so later changes on the port have no effect
  // on the job in flight. The weight counter restarts for every job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      w_count   <= '0;
      vecs_left <= '0;
    end else begin
      state <= state_next;
      if ((state == S_IDLE) && start) begin
        vecs_left <= num_vecs;
        w_count   <= '0;
      end else begin
        if (w_accept) w_count   <= w_count + 1'b1;
        if (a_accept) vecs_left <= vecs_left - 8'd1;
      end
    end
  end

  // Host-facing status and array weight path. The array shifts its weights
  // on every cycle with load high, so load must follow the accepted beat
  // exactly. That is why it is combinational from w_valid and not
  // registered.
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DRAIN) && tag_empty;
  assign w_ready     = (state == S_LOAD);
  assign a_ready     = (state == S_STREAM);
  assign arr_load    = w_accept;
  assign arr_weights = (state == S_LOAD) ? w_data : '0;

  // Tag line: a valid bit for each accepted activation beat. It runs in
  // parallel with the data through skew, array and de-skew, so its length
  // equals that round trip: one input stage, ARRAY_SIZE array hops, and
  // ARRAY_SIZE realignment stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_line <= '0;
    end else begin
      tag_line <= {tag_line[TAG_DEPTH-2:0], a_accept};
    end
  end

  assign r_valid = tag_line[TAG_DEPTH-1];

  // Input skew. Row r sits behind r+1 registers. The first register always
  // loads, taking a zero when no beat is accepted. Gaps in the input stream
  // therefore become zero bubbles, and stale data never stays in the array's
  // left edge.
  for (genvar gr = 0; gr < ARRAY_SIZE; gr++) begin : g_skew
    logic [DATA_WIDTH-1:0] line [0:gr];

    // Shift register for one array row, refilled with a zero on idle cycles.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k <= gr; k++) line[k] <= '0;
      end else begin
        line[0] <= a_accept ? a_data[gr*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= gr; k++) line[k] <= line[k-1];
      end
    end

    assign arr_activations[gr*DATA_WIDTH +: DATA_WIDTH] = line[gr];
  end

  // Output de-skew. Column c leaves the array c cycles after column 0.
  // Giving it ARRAY_SIZE-c registers makes every column land in the same
  // cycle. Data is masked with r_valid, so r_data stays zero between
  // results.
  for (genvar gc = 0; gc < ARRAY_SIZE; gc++) begin : g_deskew
    localparam int DEPTH = ARRAY_SIZE - gc;
    logic [SUM_WIDTH-1:0] line [0:DEPTH-1];

    // Realignment shift register for one result column.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) line[k] <= '0;
      end else begin
        line[0] <= arr_output_row[gc*SUM_WIDTH +: SUM_WIDTH];
        for (int k = 1; k < DEPTH; k++) line[k] <= line[k-1];
      end
    end

    assign r_data[gc*SUM_WIDTH +: SUM_WIDTH] = r_valid ? line[DEPTH-1] : '0;
  end

endmodule
